spi_ram_ctrl: RTL

Command-decoding controller with an on-board single-port RAM, sitting directly downstream of the SPI slave. It consumes the 10-bit words the SPI slave delivers on rx_data/rx_valid and decodes the command in bits [9:8]. It performs RAM address-latch, write, or read accordingly. Read data returns to the SPI slave on tx_data/tx_valid for serialisation onto MISO.

---
 rtl/spi_ram_pkg.sv | 26 ++
 rtl/spi_ram_ctrl_spram.sv | 36 +++
 rtl/spi_ram_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg
// Shared definitions for the SPI-attached RAM controller:
//   - opcode values carried in rx_data[9:8]
//   - controller FSM state encoding
//   - reject-counter ceiling and its saturating increment helper
package spi_ram_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2
  } state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Increment that sticks at ERR_CNT_MAX instead of wrapping.
  function automatic logic [7:0] err_cnt_inc(input logic [7:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/spi_ram_ctrl_spram.sv
// spram
// Single-port 8-bit RAM with a synchronous, registered read port.
// Contents and output register are not reset.
// Ports:
//   clk   in   clock
//   en    in   access enable for this cycle
//   we    in   1 = write din to addr, 0 = read addr into dout
//   addr  in   word address [ADDR_SIZE-1:0]
//   din   in   write data [7:0]
//   dout  out  read data [7:0], valid the cycle after a read access
module spram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           din,
  output logic [7:0]           dout
);

  logic [7:0] mem [MEM_DEPTH];

  // dout only changes on a read access, so it holds across writes.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= din;
      end else begin
        dout <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl
// Decodes 10-bit command words from the SPI slave and drives an on-board
// single-port RAM. Opcode rx_data[9:8]: WR_ADDR, WR_DATA, RD_ADDR, RD_DATA.
// Read data is returned two edges after the RD_DATA command as a one-cycle
// tx_valid strobe. Data commands issued before their address was ever set,
// and any word arriving while a read is in flight, are rejected.
// Ports:
//   clk       in   clock, rising edge
//   rstn      in   asynchronous active-low reset
//   rx_data   in   [9:8] opcode, [7:0] address or data
//   rx_valid  in   one-cycle strobe qualifying rx_data
//   tx_data   out  read data, holds between responses
//   tx_valid  out  one-cycle strobe qualifying tx_data
//   cmd_err   out  one-cycle pulse per rejected command
//   err_cnt   out  rejected-command count, saturating at 255
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [9:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       cmd_err,
  output logic [7:0] err_cnt
);

  state_e                state_q, state_d;
  logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]  rd_addr_q, rd_addr_d;
  logic                  wr_ok_q, wr_ok_d;
  logic                  rd_ok_q, rd_ok_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d;
  logic                  cmd_err_q, cmd_err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_SIZE-1:0]  ram_addr;
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;

  logic [1:0]            opcode;
  logic                  reject;

  assign opcode = rx_data[9:8];

  spram #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_spram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_ok_d    = wr_ok_q;
    rd_ok_d    = rd_ok_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = 1'b0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = rd_addr_q;
    ram_din    = rx_data[7:0];
    reject     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          unique case (opcode)
            OP_WR_ADDR: begin
              wr_addr_d = rx_data[ADDR_SIZE-1:0];
              wr_ok_d   = 1'b1;
            end
            OP_WR_DATA: begin
              if (wr_ok_q) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = wr_addr_q;
                if (AUTO_INC != 0) begin
                  // ADDR_SIZE-bit add wraps MEM_DEPTH-1 -> 0 for a power-of-two depth.
                  wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
                end
              end else begin
                reject = 1'b1;
              end
            end
            OP_RD_ADDR: begin
              rd_addr_d = rx_data[ADDR_SIZE-1:0];
              rd_ok_d   = 1'b1;
            end
            OP_RD_DATA: begin
              if (rd_ok_q) begin
                // RAM read issued on this edge; dout is registered by the RAM.
                ram_en   = 1'b1;
                ram_addr = rd_addr_q;
                state_d  = RD_WAIT;
                if (AUTO_INC != 0) begin
                  rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
                end
              end else begin
                reject = 1'b1;
              end
            end
            default: reject = 1'b1;
          endcase
        end
      end
      RD_WAIT: begin
        // RAM output is now valid; capture it and raise the response strobe.
        tx_data_d  = ram_dout;
        tx_valid_d = 1'b1;
        state_d    = RD_RESP;
        reject     = rx_valid;
      end
      RD_RESP: begin
        state_d = IDLE;
        reject  = rx_valid;
      end
      default: state_d = IDLE;
    endcase

    cmd_err_d = reject;
    err_cnt_d = reject ? err_cnt_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_ok_q    <= 1'b0;
      rd_ok_q    <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      err_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_ok_q    <= wr_ok_d;
      rd_ok_q    <= rd_ok_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_err_q  <= cmd_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_err  = cmd_err_q;
  assign err_cnt  = err_cnt_q;

endmodule
